// File: rtl/rr_arb_8t1_pkg.sv
// Shared types, widths and helpers for the 8-requester round-robin arbiter.
package rr_arb_8t1_pkg;

   localparam int unsigned N_REQ = 8;
   localparam int unsigned SEL_W = 3;

   typedef logic [N_REQ-1:0] req_t;
   typedef logic [SEL_W-1:0] sel_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // One-hot decode of a requester index.
   function automatic req_t onehot(input sel_t s);
      return req_t'(1) << s;
   endfunction

endpackage

// File: rtl/rr_arb_8t1_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_arb_8t1_if;
   import rr_arb_8t1_pkg::*;

   req_t req;
   req_t gnt;
   sel_t sel;
   logic busy;

   modport master (output req, input gnt, input sel, input busy);
   modport slave  (input req, output gnt, output sel, output busy);

endinterface

// File: rtl/rr_arb_8t1_pick.sv
// Rotating priority picker: first set request at or after base, wrapping.
module rr_arb_8t1_pick
   import rr_arb_8t1_pkg::*;
(
   input  req_t req,
   input  sel_t base,
   output logic found,
   output sel_t idx
);

   sel_t cand;

   // Scan requesters from base upward, modulo N_REQ; the earliest hit wins.
   always_comb begin
      found = 1'b0;
      idx   = base;
      cand  = base;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = base + SEL_W'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/rr_arb_8t1.sv
// Round-robin arbiter for a shared 8:1 mux with a bounded hold time per owner.
module rr_arb_8t1
   import rr_arb_8t1_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CW       = 5
) (
   input  logic          clk,
   input  logic          rst,
   rr_arb_8t1_if.slave   bus
);

   state_t        state;
   sel_t          last;
   sel_t          sel;
   req_t          gnt;
   logic          busy;
   logic [CW-1:0] cnt;

   req_t          pick_req;
   sel_t          pick_base;
   logic          pick_found;
   sel_t          pick_idx;
   logic          hold_done;

   // While granted, the owner is masked so a hit means someone else is waiting.
   always_comb begin
      pick_req  = bus.req;
      pick_base = last + SEL_W'(1);
      hold_done = (cnt >= CW'(MAX_HOLD - 1));
      if (state == ST_GRANT) begin
         pick_req = bus.req & ~onehot(last);
      end
   end

   rr_arb_8t1_pick u_pick (
      .req   (pick_req),
      .base  (pick_base),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Arbitration FSM; every output is registered and updated together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         last  <= '1;
         sel   <= '0;
         gnt   <= '0;
         busy  <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  state <= ST_GRANT;
                  last  <= pick_idx;
                  sel   <= pick_idx;
                  gnt   <= onehot(pick_idx);
                  busy  <= 1'b1;
                  cnt   <= '0;
               end
            end
            ST_GRANT: begin
               if (bus.req[last] && !hold_done) begin
                  cnt <= cnt + CW'(1);
               end else if (pick_found) begin
                  last <= pick_idx;
                  sel  <= pick_idx;
                  gnt  <= onehot(pick_idx);
                  cnt  <= '0;
               end else if (!bus.req[last]) begin
                  state <= ST_IDLE;
                  gnt   <= '0;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end
               // Owner still requesting with nobody waiting: keep it, count stays saturated.
            end
            default: begin
               state <= ST_IDLE;
               gnt   <= '0;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.gnt  = gnt;
   assign bus.sel  = sel;
   assign bus.busy = busy;

endmodule

// File: tb/tb_rr_arb_8t1.sv
// Directed bench for rr_arb_8t1: vector table plus hold-limit sequences.
module tb_rr_arb_8t1;
   import rr_arb_8t1_pkg::*;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic [7:0] gnt;
      logic [2:0] sel;
      logic       busy;
   } vec_t;

   logic clk;
   logic rst;
   logic mon_en;
   int   n_pass;
   int   n_total;
   vec_t vecs[$];

   rr_arb_8t1_if ifc ();

   rr_arb_8t1 #(.MAX_HOLD(16), .CW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic apply(input logic r, input logic [7:0] q);
      @(negedge clk);
      rst     = r;
      ifc.req = q;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic [7:0] q, input logic [7:0] g,
                      input logic [2:0] s, input logic b);
      vecs.push_back('{r, q, g, s, b});
   endtask

   // Grant must always equal the decode of sel/busy.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("invariant", 32'(ifc.gnt), ifc.busy ? 32'(8'h01 << ifc.sel) : 32'h0);
      end
   end

   initial begin
      int   n3;
      int   n5;
      logic seen5;

      n_pass  = 0;
      n_total = 0;
      mon_en  = 1'b0;
      rst     = 1'b1;
      ifc.req = 8'h00;

      // reset with all requesting, then release
      add(1, 8'hFF, 8'h00, 3'd0, 0);
      add(1, 8'hFF, 8'h00, 3'd0, 0);
      add(0, 8'hFF, 8'h01, 3'd0, 1);
      // rotation: owner drops for one cycle, others pending
      add(0, 8'hFE, 8'h02, 3'd1, 1);
      add(0, 8'hFD, 8'h04, 3'd2, 1);
      add(0, 8'hFB, 8'h08, 3'd3, 1);
      add(0, 8'hF7, 8'h10, 3'd4, 1);
      add(0, 8'hEF, 8'h20, 3'd5, 1);
      add(0, 8'hDF, 8'h40, 3'd6, 1);
      add(0, 8'hBF, 8'h80, 3'd7, 1);
      add(0, 8'h7F, 8'h01, 3'd0, 1);
      // idle and single-cycle pulse
      add(0, 8'h00, 8'h00, 3'd0, 0);
      add(0, 8'h10, 8'h10, 3'd4, 1);
      add(0, 8'h00, 8'h00, 3'd4, 0);
      // wrap: last=6, then 0 before 2
      add(0, 8'h40, 8'h40, 3'd6, 1);
      add(0, 8'h05, 8'h01, 3'd0, 1);
      add(0, 8'h04, 8'h04, 3'd2, 1);
      add(0, 8'h00, 8'h00, 3'd2, 0);
      // mid-grant reset
      add(0, 8'h20, 8'h20, 3'd5, 1);
      add(1, 8'h20, 8'h00, 3'd0, 0);
      add(0, 8'h20, 8'h20, 3'd5, 1);
      // reset restarts priority at 0 (without reset, 3 would win after owner 2)
      add(0, 8'h00, 8'h00, 3'd5, 0);
      add(0, 8'h04, 8'h04, 3'd2, 1);
      add(1, 8'h09, 8'h00, 3'd0, 0);
      add(0, 8'h09, 8'h01, 3'd0, 1);
      add(0, 8'h08, 8'h08, 3'd3, 1);
      add(0, 8'h00, 8'h00, 3'd3, 0);

      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].req);
         mon_en = 1'b1;
         chk($sformatf("gnt_v%0d", i),  32'(ifc.gnt),  32'(vecs[i].gnt));
         chk($sformatf("sel_v%0d", i),  32'(ifc.sel),  32'(vecs[i].sel));
         chk($sformatf("busy_v%0d", i), 32'(ifc.busy), 32'(vecs[i].busy));
      end

      // hold limit: req3 steady, req5 joins at cycle 2 -> 16 cycles of owner 3
      n3    = 0;
      seen5 = 1'b0;
      for (int i = 0; i < 40 && !seen5; i++) begin
         apply(0, (i >= 2) ? 8'h28 : 8'h08);
         if (ifc.busy && ifc.sel == 3'd3) n3++;
         else if (ifc.busy && ifc.sel == 3'd5) seen5 = 1'b1;
      end
      chk("hold_cycles", 32'(n3), 32'd16);
      chk("hold_switch", 32'(seen5), 32'd1);
      chk("hold_gnt", 32'(ifc.gnt), 32'h20);

      // lone owner past the limit keeps the bus
      n5 = 0;
      for (int i = 0; i < 40; i++) begin
         apply(0, 8'h20);
         if (ifc.busy && ifc.sel == 3'd5) n5++;
      end
      chk("solo_hold", 32'(n5), 32'd40);

      // saturated count: a newcomer takes over on the very next edge
      apply(0, 8'h28);
      chk("sat_sel", 32'(ifc.sel), 32'd3);
      chk("sat_gnt", 32'(ifc.gnt), 32'h08);

      apply(0, 8'h00);
      chk("end_idle", 32'(ifc.busy), 32'd0);

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
